// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor slice and a borrow flop; start/busy/done handshake around it.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             br, br_nxt, d, last;

  // One full-subtractor bit slice: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bin);
    logic dd, bo;
    dd = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {bo, dd};
  endfunction

  always_comb begin
    {br_nxt, d} = sub_bit(sa[0], sb[0], br);
    sr_nxt      = {d, sr[WIDTH-1:1]};
    last        = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift, partial-result accumulation and the result register;
  // diff/borrow are written only on the last bit so they never show partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state != SHIFT) begin
      if (start) begin
        sa  <= a;
        sb  <= b;
        sr  <= '0;
        cnt <= '0;
        br  <= 1'b0;
      end
    end else begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      sr  <= sr_nxt;
      br  <= br_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        diff   <= sr_nxt;
        borrow <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 (directed) and WIDTH=8 (random sweep),
// compared against an arithmetic reference: diff = (a-b) mod 2^W, borrow = (a < b).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       busy4, done4, borrow4;
  logic       busy8, done8, borrow8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  function automatic int ref_diff(input int av, input int bv, input int w);
    int m;
    m = 1 << w;
    return ((av - bv) % m + m) % m;
  endfunction

  function automatic logic ref_borrow(input int av, input int bv);
    return av < bv;
  endfunction

  // Launches one operation and waits (bounded) for done; leaves the bench at the
  // negedge where done is high. Collects observations only.
  task automatic run_op(input bit w8, input int av, input int bv,
                        output int bc, output int dv, output logic brv,
                        output bit to, output bit overlap);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; a8 = 8'(av); b8 = 8'(bv); end
    else    begin start4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    bc = 0; dv = 0; brv = 1'b0; to = 1'b1; overlap = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (w8 ? (busy8 && done8) : (busy4 && done4)) overlap = 1'b1;
      if (w8 ? done8 : done4) begin
        dv  = w8 ? int'(diff8) : int'(diff4);
        brv = w8 ? borrow8 : borrow4;
        to  = 1'b0;
        break;
      end
      if (w8 ? busy8 : busy4) bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy4, done4, diff4, borrow4} !== 7'b0) begin
      errors++;
      $display("FAIL reset_w4: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy4, done4, diff4, borrow4);
    end
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy8, done8, diff8, borrow8);
    end
    // start coinciding with reset must be dropped
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_start: got busy=%b done=%b, want 0 0", busy4, done4);
    end
  endtask

  task automatic test_basic();
    int av[5] = '{9, 3, 0, 15, 0};
    int bv[5] = '{3, 9, 0, 15, 1};
    int bc, dv;
    logic brv;
    bit to, ov;
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, av[k], bv[k], bc, dv, brv, to, ov);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL basic_timeout[%0d]: no done within bound, want done", k);
        continue;
      end
      checks++;
      if (dv !== ref_diff(av[k], bv[k], 4) || brv !== ref_borrow(av[k], bv[k])) begin
        errors++;
        $display("FAIL basic_result %0d-%0d: got diff=%0d borrow=%b, want diff=%0d borrow=%b",
                 av[k], bv[k], dv, brv, ref_diff(av[k], bv[k], 4), ref_borrow(av[k], bv[k]));
      end
      checks++;
      if (bc !== 4 || ov) begin
        errors++;
        $display("FAIL basic_busy[%0d]: got busy cycles=%0d overlap=%b, want 4 and 0", k, bc, ov);
      end
      checks++;
      if (((dv + bv[k]) % 16) !== av[k]) begin
        errors++;
        $display("FAIL basic_recover[%0d]: got diff+b=%0d, want a=%0d", k, (dv + bv[k]) % 16, av[k]);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || int'(diff4) !== dv) begin
        errors++;
        $display("FAIL basic_hold[%0d]: got done=%b busy=%b diff=%0d, want 0 0 %0d", k, done4, busy4, diff4, dv);
      end
    end
  endtask

  task automatic test_start_ignored();
    int bc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done4) begin seen = 1'b1; break; end
      if (busy4) bc++;
      if (i == 1) begin start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; end
      else        start4 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!seen || diff4 !== 4'b0110 || borrow4 !== 1'b0 || bc !== 4) begin
      errors++;
      $display("FAIL start_in_shift: got seen=%b diff=%b borrow=%b busy cycles=%0d, want 1 0110 0 4",
               seen, diff4, borrow4, bc);
    end
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_shift_idle: got busy=%b done=%b, want 0 0", busy4, done4);
    end
  endtask

  task automatic test_reset_mid();
    int bc, dv;
    logic brv;
    bit to, ov;
    bit spurious = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);          // second SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'b0 || borrow4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b diff=%b borrow=%b, want 0 0 0000 0",
               busy4, done4, diff4, borrow4);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 || busy4) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL reset_mid_no_done: got activity after aborted op, want none");
    end
    run_op(1'b0, 5, 4, bc, dv, brv, to, ov);
    checks++;
    if (to || dv !== 1 || brv !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: got timeout=%b diff=%0d borrow=%b, want 0 1 0", to, dv, brv);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int t0 = -1;
    int t1 = -1;
    int dres[2];
    logic bres[2];
    bit ov = 1'b0;
    bit gap = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy4 && done4) ov = 1'b1;
      if (n == 1 && t == t0 + 1) begin
        start4 = 1'b0;
        if (!busy4) gap = 1'b1;
      end
      if (done4) begin
        dres[n] = int'(diff4);
        bres[n] = borrow4;
        if (n == 0) begin t0 = t; a4 = 4'd2; b4 = 4'd6; end
        else        t1 = t;
        n++;
        if (n == 2) break;
      end
    end
    start4 = 1'b0;
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, want 2", n);
    end else begin
      checks++;
      if (dres[0] !== ref_diff(12, 5, 4) || bres[0] !== ref_borrow(12, 5) ||
          dres[1] !== ref_diff(2, 6, 4) || bres[1] !== ref_borrow(2, 6)) begin
        errors++;
        $display("FAIL b2b_result: got %0d/%b then %0d/%b, want %0d/%b then %0d/%b",
                 dres[0], bres[0], dres[1], bres[1], ref_diff(12, 5, 4), ref_borrow(12, 5),
                 ref_diff(2, 6, 4), ref_borrow(2, 6));
      end
      checks++;
      if (t1 - t0 !== 5 || gap || ov) begin
        errors++;
        $display("FAIL b2b_timing: got spacing=%0d idle_gap=%b overlap=%b, want 5 0 0", t1 - t0, gap, ov);
      end
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_width: got done=%b after pulse, want 0", done4);
    end
  endtask

  task automatic test_random_w8();
    int bc, dv, av, bv;
    logic brv;
    bit to, ov;
    for (int k = 0; k < 40; k++) begin
      av = (k == 0) ? 0 : (k == 1) ? 255 : int'($urandom_range(0, 255));
      bv = (k == 0) ? 255 : (k == 1) ? 0 : int'($urandom_range(0, 255));
      run_op(1'b1, av, bv, bc, dv, brv, to, ov);
      checks++;
      if (to || dv !== ref_diff(av, bv, 8) || brv !== ref_borrow(av, bv) || bc !== 8 || ov) begin
        errors++;
        $display("FAIL rand_w8 %0d-%0d: got diff=%0d borrow=%b busy=%0d timeout=%b, want diff=%0d borrow=%b busy=8",
                 av, bv, dv, brv, bc, to, ref_diff(av, bv, 8), ref_borrow(av, bv));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first, with a borrow flip-flop and a start/done handshake. It is the counterpart to the team's combinational 4-bit ripple parallel adder: it implements the reverse operation, subtraction, in the serial domain and trades latency for one bit-slice of logic. It sits beside the adder in the arithmetic lab datapath. Its outputs can be cross-checked against adder results: diff + B recovers A.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; captured on the edge that accepts start
- b  input  WIDTH  subtrahend; captured on the edge that accepts start
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse when diff/borrow update
- diff  output  WIDTH  (a − b) mod 2^WIDTH, held until the next completion
- borrow  output  1  final borrow out (1 iff a < b unsigned), held with diff

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values: busy=0, done=0, diff=0, borrow=0. The internal shift registers, the bit counter and the borrow flop are also cleared.
- IDLE/DONE with start=1:
  - Load sa←a, sb←b, br←0, cnt←0, sr←0.
  - Go to SHIFT.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- SHIFT, each edge:
  - x=sa[0], y=sb[0]
  - d = x^y^br
  - br ← (~x & y) | (~(x^y) & br)
  - sr ← {d, sr[WIDTH-1:1]}
  - sa, sb shift right by one with zero fill
  - cnt ← cnt+1
- SHIFT exit: on the edge where cnt == WIDTH-1:
  - diff ← {d, sr[WIDTH-1:1]}, borrow ← br_next
  - Go to DONE.
- start is ignored in SHIFT. Changes on a and b are ignored outside the accept edge.
- diff and borrow change only on the completion edge or on reset. They never show partial results.
- cnt width is $clog2(WIDTH), minimum 1 bit. It does not wrap during a valid operation.

## Timing
- Let E0 be the edge that accepts start.
- busy=1 from after E0 until after edge E_WIDTH, i.e. exactly WIDTH cycles.
- done=1 and new diff/borrow appear after E_WIDTH. done drops after E_WIDTH+1.
- Latency from start to done is WIDTH edges. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back operation: start=1 during the DONE cycle is accepted on E_WIDTH+1. The next busy rises with no IDLE cycle in between, and done still pulses for exactly one cycle.
- Reset mid-SHIFT takes effect on that edge:
  - Return to IDLE, with all outputs at their reset values.
  - The partial operation is discarded, and no done pulse is produced.
- rst=1 and start=1 on the same edge: reset wins and start is dropped.
- busy and done are never both high. done is never high for two consecutive cycles except across a reset.

## Test plan
- WIDTH=4, a=9, b=3, start pulse → busy high 4 cycles, then done=1 with diff=0110 and borrow=0.
- a=3, b=9 → diff=1010 and borrow=1. Check diff + b mod 16 == a.
- a=0, b=0 and a=15, b=15 → diff=0000 and borrow=0 for both. Then a=0, b=1 → diff=1111 and borrow=1.
- During SHIFT, drive start=1 with a=7, b=2 → ignored. The original result completes on time and busy stays exactly 4 cycles.
- Assert rst at SHIFT cycle 2 → next cycle busy=0, done=0, diff=0, borrow=0. No done pulse follows, and a fresh start=1 with a=5, b=4 gives diff=0001 and borrow=0.
- Back-to-back: start held high across the DONE cycle with a=12, b=5 then a=2, b=6 → done pulses for diff=0111 (borrow 0), then for diff=1100 (borrow 1), with done pulses spaced 5 cycles apart. Repeat with a random sweep at WIDTH=8 against a reference model.
